// File: rtl/itof_pipe_if.sv
// rtl/itof_pipe_if.sv - operand/result handshake bundle for itof_pipe (out_inexact only with ITOF_PIPE_FLAGS_EN)
interface itof_pipe_if #(
    parameter int INT_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [INT_W-1:0] in_data;
    logic             in_unsigned;
    logic [1:0]       in_rm;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
`ifdef ITOF_PIPE_FLAGS_EN
    logic             out_inexact;
`endif

    modport master (
        output in_valid, in_data, in_unsigned, in_rm, out_ready,
        input  in_ready, out_valid, out_data
`ifdef ITOF_PIPE_FLAGS_EN
        , input out_inexact
`endif
    );

    modport slave (
        input  in_valid, in_data, in_unsigned, in_rm, out_ready,
        output in_ready, out_valid, out_data
`ifdef ITOF_PIPE_FLAGS_EN
        , output out_inexact
`endif
    );
endinterface

// File: rtl/itof_pipe.sv
// rtl/itof_pipe.sv - 3-stage INT_W-bit integer to binary32 converter; ITOF_PIPE_FLAGS_EN adds out_inexact
module itof_pipe #(
    parameter int INT_W = 32
) (
    input logic       clk,
    input logic       rstn,
    itof_pipe_if.slave bus
);
    localparam int LZW   = $clog2(INT_W + 1);
    localparam int EXT_W = INT_W + 24;

    logic advance;
    assign advance      = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = advance;

    // stage 1: sign, magnitude, leading-zero count
    logic             s0;
    logic [INT_W-1:0] mag0;
    logic [LZW-1:0]   lz0;
    logic [1:0]       rm0;

    always_comb begin
        s0   = !bus.in_unsigned && bus.in_data[INT_W-1];
        mag0 = s0 ? -bus.in_data : bus.in_data;
        rm0  = (bus.in_rm == 2'b11) ? 2'b00 : bus.in_rm;
        lz0  = LZW'(INT_W);
        for (int i = 0; i < INT_W; i++) begin
            if (mag0[i]) lz0 = LZW'(INT_W - 1 - i);
        end
    end

    logic             v1, s1, zero1;
    logic [INT_W-1:0] mag1;
    logic [LZW-1:0]   lz1;
    logic [1:0]       rm1;

    // stage 2: normalise and round; the extra shift drops the hidden one
    logic [INT_W-1:0] frac_all;
    logic [EXT_W-1:0] ext2;
    logic [22:0]      mant2;
    logic             guard2, sticky2, inc2, carry2;
    logic [22:0]      frac2;

    always_comb begin
        frac_all = mag1 << ({1'b0, lz1} + 1'b1);
        ext2     = {frac_all, 24'b0};
        mant2    = ext2[EXT_W-1 -: 23];
        guard2   = ext2[EXT_W-24];
        sticky2  = |ext2[EXT_W-25:0];
        case (rm1)
            2'b01:   inc2 = 1'b0;
            2'b10:   inc2 = guard2;
            default: inc2 = guard2 && (sticky2 || mant2[0]);
        endcase
        {carry2, frac2} = {1'b0, mant2} + 24'(inc2);
    end

    logic           v2, s2, zero2, carry_q;
    logic [LZW-1:0] lz2;
    logic [22:0]    frac_q;
`ifdef ITOF_PIPE_FLAGS_EN
    logic           inx2;
`endif

    // stage 3: exponent and packing; a rounding carry leaves the fraction at zero
    logic [7:0]  exp3;
    logic [31:0] data3;

    always_comb begin
        exp3  = 8'(127 + INT_W - 1) - 8'(lz2) + 8'(carry_q);
        data3 = zero2 ? 32'h0 : {s2, exp3, frac_q};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v1            <= 1'b0;
            s1            <= 1'b0;
            zero1         <= 1'b0;
            mag1          <= '0;
            lz1           <= '0;
            rm1           <= 2'b00;
            v2            <= 1'b0;
            s2            <= 1'b0;
            zero2         <= 1'b0;
            carry_q       <= 1'b0;
            lz2           <= '0;
            frac_q        <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= 32'h0;
`ifdef ITOF_PIPE_FLAGS_EN
            inx2            <= 1'b0;
            bus.out_inexact <= 1'b0;
`endif
        end else if (advance) begin
            v1            <= bus.in_valid;
            s1            <= s0;
            zero1         <= (mag0 == '0);
            mag1          <= mag0;
            lz1           <= lz0;
            rm1           <= rm0;
            v2            <= v1;
            s2            <= s1;
            zero2         <= zero1;
            carry_q       <= carry2;
            lz2           <= lz1;
            frac_q        <= frac2;
            bus.out_valid <= v2;
            bus.out_data  <= data3;
`ifdef ITOF_PIPE_FLAGS_EN
            inx2            <= guard2 || sticky2;
            bus.out_inexact <= inx2 && !zero2;
`endif
        end
    end
endmodule

// File: tb/tb_itof_pipe.sv
// tb/tb_itof_pipe.sv - scoreboard bench for itof_pipe (INT_W=32)
module tb_itof_pipe;
    localparam int INT_W = 32;

    typedef struct {
        logic [31:0] data;
        logic        inx;
        int          cyc;
    } exp_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   last_stall = -1;
    int   or_mode = 0;
    bit   acc_flag;
    exp_t sb[$];
    exp_t pend;

    itof_pipe_if #(.INT_W(INT_W)) bus ();
    itof_pipe #(.INT_W(INT_W)) dut (.clk(clk), .rstn(rstn), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // reference: right-shift magnitude and compare the discarded remainder against one half
    function automatic logic [32:0] model(input logic [31:0] d, input bit uns, input logic [1:0] rm);
        logic        s;
        logic [63:0] mag, q, rem, half;
        int          p, sh;
        bit          inc;
        s   = !uns && d[31];
        mag = s ? (64'h1_0000_0000 - {32'b0, d}) : {32'b0, d};
        if (mag == 64'd0) return 33'd0;
        p = 0;
        for (int i = 0; i < 64; i++) if (mag[i]) p = i;
        if (p <= 23) begin
            q = mag << (23 - p); rem = 64'd0; half = 64'd1;
        end else begin
            sh = p - 23; q = mag >> sh; rem = mag - (q << sh); half = 64'd1 << (sh - 1);
        end
        case (rm)
            2'b01:   inc = 1'b0;
            2'b10:   inc = (rem >= half);
            default: inc = (rem > half) || (rem == half && q[0]);
        endcase
        q = q + 64'(inc);
        if (q[24]) begin q = q >> 1; p++; end
        return {s, 8'(127 + p), q[22:0], rem != 64'd0};
    endfunction

    task automatic step();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (!bus.out_ready) last_stall = cyc;
        if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                check("spurious_out", 32'(bus.out_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                check("out_data", bus.out_data, e.data);
`ifdef ITOF_PIPE_FLAGS_EN
                check("out_inexact", 32'(bus.out_inexact), 32'(e.inx));
`endif
                if (e.cyc > last_stall) check("latency", 32'(cyc - e.cyc), 32'd3);
            end
        end
        acc_flag = bus.in_valid && bus.in_ready;
        if (acc_flag) begin
            pend.cyc = cyc;
            sb.push_back(pend);
        end
        @(posedge clk);
        #1;
        if (acc_flag) bus.in_valid = 1'b0;
        if (or_mode == 0)      bus.out_ready = 1'b1;
        else if (or_mode == 1) bus.out_ready = ~bus.out_ready;
        else                   bus.out_ready = 1'b0;
    endtask

    task automatic drive_op(input logic [31:0] d, input bit uns, input logic [1:0] rm,
                            input logic [31:0] ed, input logic ei);
        bus.in_valid    = 1'b1;
        bus.in_data     = d;
        bus.in_unsigned = uns;
        bus.in_rm       = rm;
        pend.data       = ed;
        pend.inx        = ei;
    endtask

    task automatic wait_acc();
        bit ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            step();
            ok = acc_flag;
        end
        check("accept", 32'(ok), 32'd1);
    endtask

    task automatic send(input logic [31:0] d, input bit uns, input logic [1:0] rm,
                        input logic [31:0] ed, input logic ei);
        drive_op(d, uns, rm, ed, ei);
        wait_acc();
    endtask

    task automatic send_m(input logic [31:0] d, input bit uns, input logic [1:0] rm);
        logic [32:0] r;
        r = model(d, uns, rm);
        send(d, uns, rm, r[32:1], r[0]);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n && sb.size() != 0; i++) step();
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        logic [31:0] d, hold;
        logic [32:0] r;
        bit          got, seen;

        bus.in_valid    = 1'b0;
        bus.in_data     = '0;
        bus.in_unsigned = 1'b0;
        bus.in_rm       = 2'b00;
        bus.out_ready   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", bus.out_data, 32'h0);
        rstn = 1'b1;
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);

        send(32'h0000_0000, 1'b0, 2'b00, 32'h0000_0000, 1'b0);
        send(32'h0000_0001, 1'b0, 2'b00, 32'h3F80_0000, 1'b0);
        send(32'hFFFF_FFFF, 1'b0, 2'b00, 32'hBF80_0000, 1'b0);
        send(32'hFFFF_FFFF, 1'b1, 2'b00, 32'h4F80_0000, 1'b1);
        send(32'h8000_0000, 1'b0, 2'b00, 32'hCF00_0000, 1'b0);
        send(32'h7FFF_FFFF, 1'b0, 2'b00, 32'h4F00_0000, 1'b1);
        send(32'h7FFF_FFFF, 1'b0, 2'b01, 32'h4EFF_FFFF, 1'b1);
        send(32'h8000_0001, 1'b0, 2'b01, 32'hCEFF_FFFF, 1'b1);
        send(32'h0100_0001, 1'b0, 2'b00, 32'h4B80_0000, 1'b1);
        send(32'h0100_0001, 1'b0, 2'b01, 32'h4B80_0000, 1'b1);
        send(32'h0100_0001, 1'b0, 2'b10, 32'h4B80_0001, 1'b1);
        send(32'h0100_0001, 1'b0, 2'b11, 32'h4B80_0000, 1'b1);
        send(32'h0000_0000, 1'b0, 2'b10, 32'h0000_0000, 1'b0);
        drain(20);

        for (int i = 0; i < 20; i++) begin
            d = $urandom >> $urandom_range(0, 31);
            send_m(d, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
        end
        drain(20);

        or_mode = 1;
        for (int i = 0; i < 8; i++) send_m($urandom, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
        or_mode = 2;
        d = $urandom;
        r = model(d, 1'b0, 2'b00);
        drive_op(d, 1'b0, 2'b00, r[32:1], r[0]);
        got = 1'b0;
        repeat (5) begin
            step();
            got |= acc_flag;
        end
        check("stall_out_valid", 32'(bus.out_valid), 32'd1);
        check("stall_in_ready", 32'(bus.in_ready), 32'd0);
        hold = bus.out_data;
        step();
        got |= acc_flag;
        check("stall_hold", bus.out_data, hold);
        or_mode = 0;
        if (!got) wait_acc();
        drain(40);

        for (int i = 0; i < 3; i++) send_m($urandom, 1'b0, 2'b00);
        #2;
        rstn = 1'b0;
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_out_data", bus.out_data, 32'h0);
        sb.delete();
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            step();
            seen |= bus.out_valid;
        end
        check("post_rst_quiet", 32'(seen), 32'd0);
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
